// File: rtl/bitfield_pkg.sv
// Shared op encoding and width-generic rotate / low-ones helpers for the bitfield pipeline.
package bitfield_pkg;

    localparam int BF_XLEN_DEF = 64;
    localparam int BF_MAX_W    = 128;

    typedef enum logic [1:0] {
        BF_UBFM = 2'd0,
        BF_SBFM = 2'd1,
        BF_BFM  = 2'd2,
        BF_RSVD = 2'd3
    } bf_op_t;

    typedef logic [BF_MAX_W-1:0] bf_word_t;

    // n low bits set; n == full width yields all ones without overflowing the shift
    function automatic bf_word_t ones(input int unsigned n);
        bf_word_t m;
        if (n >= BF_MAX_W) begin
            m = {BF_MAX_W{1'b1}};
        end else begin
            m = (bf_word_t'(1'b1) << n) - bf_word_t'(1'b1);
        end
        return m;
    endfunction

    function automatic bf_word_t ror(input bf_word_t x, input int unsigned r, input int unsigned w);
        bf_word_t y;
        if (r == 32'd0) begin
            y = x & ones(w);
        end else begin
            y = ((x >> r) | (x << (w - r))) & ones(w);
        end
        return y;
    endfunction

endpackage

// File: rtl/bitfield_pipe_mask_gen.sv
// Combinational field masks for the bitfield ops: wmask selects the rotated field,
// tmask selects the bits kept from the bottom result before top fill.
module bf_mask_gen
    import bitfield_pkg::*;
#(
    parameter  int XLEN  = BF_XLEN_DEF,
    localparam int IMM_W = $clog2(XLEN)
) (
    input  logic [IMM_W-1:0] immr,
    input  logic [IMM_W-1:0] imms,
    output logic [XLEN-1:0]  wmask,
    output logic [XLEN-1:0]  tmask
);

    logic [IMM_W-1:0] diff_s;

    // IMM_W-bit subtraction wraps exactly mod XLEN since XLEN is a power of two
    always_comb begin
        diff_s = imms - immr;
        wmask  = XLEN'(ror(ones(32'(imms) + 32'd1), 32'(immr), 32'(XLEN)));
        tmask  = XLEN'(ones(32'(diff_s) + 32'd1));
    end

endmodule

// File: rtl/bitfield_pipe.sv
// Pipelined UBFM/SBFM/BFM unit: stage 1 rotates and builds masks, stage 2 forms the
// bottom/top candidates, the output stage merges them and holds until the CDB accepts.
module bitfield_pipe
    import bitfield_pkg::*;
#(
    parameter  int XLEN  = BF_XLEN_DEF,
    parameter  int TAG_W = 6,
    localparam int IMM_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_src,
    input  logic [XLEN-1:0]  in_dst,
    input  logic [IMM_W-1:0] in_immr,
    input  logic [IMM_W-1:0] in_imms,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_res,
    output logic [TAG_W-1:0] out_tag
);

    logic             out_adv_s;
    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             s1_load_s;
    logic             s2_load_s;
    logic             out_load_s;
    logic [XLEN-1:0]  rot_s;
    logic [XLEN-1:0]  wmask_s;
    logic [XLEN-1:0]  tmask_s;
    logic             sbit_s;
    logic [XLEN-1:0]  bot_s;
    logic [XLEN-1:0]  top_s;

    logic             s1_valid_d, s1_valid_q;
    bf_op_t           s1_op_d,    s1_op_q;
    logic [XLEN-1:0]  s1_rot_d,   s1_rot_q;
    logic [XLEN-1:0]  s1_wmask_d, s1_wmask_q;
    logic [XLEN-1:0]  s1_tmask_d, s1_tmask_q;
    logic             s1_sbit_d,  s1_sbit_q;
    logic [XLEN-1:0]  s1_dst_d,   s1_dst_q;
    logic [TAG_W-1:0] s1_tag_d,   s1_tag_q;

    logic             s2_valid_d, s2_valid_q;
    logic [XLEN-1:0]  s2_bot_d,   s2_bot_q;
    logic [XLEN-1:0]  s2_top_d,   s2_top_q;
    logic [XLEN-1:0]  s2_tmask_d, s2_tmask_q;
    logic [TAG_W-1:0] s2_tag_d,   s2_tag_q;

    logic             out_valid_d, out_valid_q;
    logic [XLEN-1:0]  out_res_d,   out_res_q;
    logic [TAG_W-1:0] out_tag_d,   out_tag_q;

    bf_mask_gen #(
        .XLEN (XLEN)
    ) u_mask_gen (
        .immr  (in_immr),
        .imms  (in_imms),
        .wmask (wmask_s),
        .tmask (tmask_s)
    );

    // Backpressure chain: a stage may load when it is empty or its own contents move on
    always_comb begin
        out_adv_s  = !out_valid_q || out_ready;
        s2_adv_s   = !s2_valid_q || out_adv_s;
        s1_adv_s   = !s1_valid_q || s2_adv_s;
        in_ready   = s1_adv_s;
        s1_load_s  = s1_adv_s && in_valid;
        s2_load_s  = s2_adv_s && s1_valid_q;
        out_load_s = out_adv_s && s2_valid_q;
        rot_s      = XLEN'(ror(bf_word_t'(in_src), 32'(in_immr), 32'(XLEN)));
        sbit_s     = in_src[in_imms];
    end

    // Stage 1 capture: rotated source, both masks, sign bit and passthrough fields
    always_comb begin
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        s1_op_d    = s1_load_s ? bf_op_t'(in_op) : s1_op_q;
        s1_rot_d   = s1_load_s ? rot_s           : s1_rot_q;
        s1_wmask_d = s1_load_s ? wmask_s         : s1_wmask_q;
        s1_tmask_d = s1_load_s ? tmask_s         : s1_tmask_q;
        s1_sbit_d  = s1_load_s ? sbit_s          : s1_sbit_q;
        s1_dst_d   = s1_load_s ? in_dst          : s1_dst_q;
        s1_tag_d   = s1_load_s ? in_tag          : s1_tag_q;
    end

    // Per-op bottom field and the value that fills bits above the field
    always_comb begin
        bot_s = {XLEN{1'b0}};
        top_s = {XLEN{1'b0}};
        case (s1_op_q)
            BF_UBFM: begin
                bot_s = s1_rot_q & s1_wmask_q;
                top_s = {XLEN{1'b0}};
            end
            BF_SBFM: begin
                bot_s = s1_rot_q & s1_wmask_q;
                top_s = {XLEN{s1_sbit_q}};
            end
            BF_BFM: begin
                bot_s = (s1_dst_q & ~s1_wmask_q) | (s1_rot_q & s1_wmask_q);
                top_s = s1_dst_q;
            end
            default: begin
                bot_s = {XLEN{1'b0}};
                top_s = {XLEN{1'b0}};
            end
        endcase
    end

    // Stage 2 and output stage next-state
    always_comb begin
        if (flush) begin
            s2_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            s2_valid_d  = s2_adv_s  ? s1_valid_q : s2_valid_q;
            out_valid_d = out_adv_s ? s2_valid_q : out_valid_q;
        end
        s2_bot_d   = s2_load_s ? bot_s      : s2_bot_q;
        s2_top_d   = s2_load_s ? top_s      : s2_top_q;
        s2_tmask_d = s2_load_s ? s1_tmask_q : s2_tmask_q;
        s2_tag_d   = s2_load_s ? s1_tag_q   : s2_tag_q;
        out_res_d  = out_load_s ? ((s2_top_q & ~s2_tmask_q) | (s2_bot_q & s2_tmask_q)) : out_res_q;
        out_tag_d  = out_load_s ? s2_tag_q : out_tag_q;
    end

    // Pipeline registers; reset empties every stage and zeroes the visible result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= BF_UBFM;
            s1_rot_q    <= {XLEN{1'b0}};
            s1_wmask_q  <= {XLEN{1'b0}};
            s1_tmask_q  <= {XLEN{1'b0}};
            s1_sbit_q   <= 1'b0;
            s1_dst_q    <= {XLEN{1'b0}};
            s1_tag_q    <= {TAG_W{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_bot_q    <= {XLEN{1'b0}};
            s2_top_q    <= {XLEN{1'b0}};
            s2_tmask_q  <= {XLEN{1'b0}};
            s2_tag_q    <= {TAG_W{1'b0}};
            out_valid_q <= 1'b0;
            out_res_q   <= {XLEN{1'b0}};
            out_tag_q   <= {TAG_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_rot_q    <= s1_rot_d;
            s1_wmask_q  <= s1_wmask_d;
            s1_tmask_q  <= s1_tmask_d;
            s1_sbit_q   <= s1_sbit_d;
            s1_dst_q    <= s1_dst_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_bot_q    <= s2_bot_d;
            s2_top_q    <= s2_top_d;
            s2_tmask_q  <= s2_tmask_d;
            s2_tag_q    <= s2_tag_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // Drive the output ports straight from the output stage registers
    always_comb begin
        out_valid = out_valid_q;
        out_res   = out_res_q;
        out_tag   = out_tag_q;
    end

endmodule

// File: tb/tb_bitfield_pipe.sv
// Self-checking bench for bitfield_pipe: directed vectors, back-to-back, backpressure,
// flush, async reset and randomized ops against a per-bit reference model.
module tb_bitfield_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [63:0] in_src = 64'h0;
    logic [63:0] in_dst = 64'h0;
    logic [5:0]  in_immr = 6'd0;
    logic [5:0]  in_imms = 6'd0;
    logic [5:0]  in_tag = 6'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_res;
    logic [5:0]  out_tag;

    int checks = 0;
    int errors = 0;
    logic [69:0] exp_q[$];
    logic [69:0] obs_q[$];

    bitfield_pipe #(.XLEN(64), .TAG_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src    (in_src),
        .in_dst    (in_dst),
        .in_immr   (in_immr),
        .in_imms   (in_imms),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Record every completed output transfer; inputs only change just after posedge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs_q.push_back({out_tag, out_res});
    end

    // Bit i of the result, straight from the field definitions (wmask bit i set iff (i+r)%64 <= s)
    function automatic logic [63:0] ref_bf(input logic [1:0] op, input logic [63:0] src,
                                           input logic [63:0] dst, input int r, input int s);
        logic [63:0] res;
        int d;
        d = (s - r + 64) % 64;
        res = 64'h0;
        for (int i = 0; i < 64; i++) begin
            logic rb, inw, lo;
            rb  = src[(i + r) % 64];
            inw = (((i + r) % 64) <= s);
            lo  = (i <= d);
            case (op)
                2'd0:    res[i] = rb & inw & lo;
                2'd1:    res[i] = lo ? (rb & inw) : src[s];
                2'd2:    res[i] = lo ? (inw ? rb : dst[i]) : dst[i];
                default: res[i] = 1'b0;
            endcase
        end
        return res;
    endfunction

    task automatic send(input logic [1:0] op, input logic [63:0] src, input logic [63:0] dst,
                        input logic [5:0] r, input logic [5:0] s, input logic [5:0] tag,
                        input logic [63:0] expv);
        int n;
        n = 0;
        in_op = op; in_src = src; in_dst = dst; in_immr = r; in_imms = s; in_tag = tag;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1 (tag %0d)", in_ready, tag);
        end else begin
            exp_q.push_back({tag, expv});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int base, output bit ok);
        int n;
        n = 0;
        while ((obs_q.size() - base) < exp_q.size() && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        ok = (n < 2000);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (out_res !== 64'h0) begin errors++; $display("FAIL rst_out_res: got %h required 0", out_res); end
        checks++; if (out_tag !== 6'h0) begin errors++; $display("FAIL rst_out_tag: got %h required 0", out_tag); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        exp_q.delete();
        out_ready = 1'b1;
        send(2'd0, 64'hFF, 64'h0, 6'd1, 6'd3, 6'd9, 64'h7);
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid=%b required 0 after edge N+1", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_res !== 64'h7 || out_tag !== 6'd9) begin
            errors++;
            $display("FAIL lat_n2: valid=%b res=%h tag=%0d required 1/7/9", out_valid, out_res, out_tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int base; bit ok; time t0;
        base = obs_q.size(); exp_q.delete(); out_ready = 1'b1;
        t0 = $time;
        send(2'd0, 64'h1234, 64'h0, 6'd60, 6'd59, 6'd1, 64'h12340);
        send(2'd0, 64'hABCD, 64'h0, 6'd8, 6'd63, 6'd2, 64'hAB);
        send(2'd1, 64'h80, 64'h0, 6'd0, 6'd7, 6'd3, 64'hFFFF_FFFF_FFFF_FF80);
        send(2'd2, 64'h5, 64'hFFFF, 6'd60, 6'd3, 6'd4, 64'hFF5F);
        send(2'd1, 64'h8000_0000_0000_0000, 64'h0, 6'd4, 6'd63, 6'd5, 64'hF800_0000_0000_0000);
        send(2'd3, 64'hDEAD, 64'hBEEF, 6'd7, 6'd9, 6'd6, 64'h0);
        checks++;
        if (($time - t0) != 60) begin errors++; $display("FAIL b2b_rate: %0t ns for 6 issues required 60", $time - t0); end
        wait_drain(base, ok);
        checks++;
        if (!ok || (obs_q.size() - base) != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: outputs=%0d required %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= obs_q.size()) begin
                errors++; $display("FAIL b2b_item%0d: missing, required %h", i, exp_q[i]);
            end else if (obs_q[base + i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_item%0d: got %h required %h", i, obs_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int base; bit ok;
        base = obs_q.size(); exp_q.delete(); out_ready = 1'b0;
        send(2'd0, 64'hFF, 64'h0, 6'd1, 6'd3, 6'd10, 64'h7);
        send(2'd2, 64'h5, 64'hFFFF, 6'd60, 6'd3, 6'd11, 64'hFF5F);
        send(2'd1, 64'h80, 64'h0, 6'd0, 6'd7, 6'd12, 64'hFFFF_FFFF_FFFF_FF80);
        fork
            send(2'd0, 64'hABCD, 64'h0, 6'd8, 6'd63, 6'd13, 64'hAB);
            begin
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
                    checks++;
                    if (out_valid !== 1'b1 || {out_tag, out_res} !== exp_q[0]) begin
                        errors++; $display("FAIL bp_hold: valid=%b out=%h required 1/%h", out_valid, {out_tag, out_res}, exp_q[0]);
                    end
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        wait_drain(base, ok);
        checks++;
        if (!ok || (obs_q.size() - base) != 4) begin
            errors++; $display("FAIL bp_count: outputs=%0d required 4", obs_q.size() - base);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= obs_q.size()) begin
                errors++; $display("FAIL bp_item%0d: missing, required %h", i, exp_q[i]);
            end else if (obs_q[base + i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_item%0d: got %h required %h", i, obs_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        int base; bit ok; bit done;
        logic [1:0] op; logic [63:0] src, dst; logic [5:0] r, s;
        base = obs_q.size(); exp_q.delete(); done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    op  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                    src = {$urandom, $urandom};
                    dst = {$urandom, $urandom};
                    r   = 6'($urandom);
                    s   = 6'($urandom);
                    case ($urandom_range(0, 7))
                        0: s = 6'd63;
                        1: r = 6'd0;
                        2: begin r = 6'd0; s = 6'd63; end
                        3: s = r;
                        default: ;
                    endcase
                    send(op, src, dst, r, s, 6'(i), ref_bf(op, src, dst, int'(r), int'(s)));
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain(base, ok);
        checks++;
        if (!ok || (obs_q.size() - base) != exp_q.size()) begin
            errors++; $display("FAIL rnd_count: outputs=%0d required %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= obs_q.size()) begin
                errors++; $display("FAIL rnd_item%0d: missing, required %h", i, exp_q[i]);
            end else if (obs_q[base + i] !== exp_q[i]) begin
                errors++; $display("FAIL rnd_item%0d: got %h required %h", i, obs_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_flush;
        int base; int seen; bit ok;
        base = obs_q.size(); exp_q.delete(); out_ready = 1'b1; seen = 0;
        send(2'd0, 64'h1234, 64'h0, 6'd60, 6'd59, 6'd20, 64'h12340);
        send(2'd1, 64'h80, 64'h0, 6'd0, 6'd7, 6'd21, 64'hFFFF_FFFF_FFFF_FF80);
        in_op = 2'd2; in_src = 64'h5; in_dst = 64'hFFFF; in_immr = 6'd60; in_imms = 6'd3; in_tag = 6'd22;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        exp_q.delete();
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || obs_q.size() != base) begin
            errors++; $display("FAIL flush_drop: out_valid cycles=%0d required 0", seen);
        end
        @(posedge clk); #1;
        base = obs_q.size();
        send(2'd0, 64'hFF, 64'h0, 6'd1, 6'd3, 6'd23, 64'h7);
        wait_drain(base, ok);
        checks++;
        if (!ok || (obs_q.size() - base) != 1) begin
            errors++; $display("FAIL flush_after_count: outputs=%0d required 1", obs_q.size() - base);
        end else if (obs_q[base] !== exp_q[0]) begin
            errors++; $display("FAIL flush_after: got %h required %h", obs_q[base], exp_q[0]);
        end
    endtask

    task automatic test_async_reset;
        int base;
        exp_q.delete(); out_ready = 1'b0;
        send(2'd0, 64'hFF, 64'h0, 6'd1, 6'd3, 6'd30, 64'h7);
        send(2'd0, 64'hABCD, 64'h0, 6'd8, 6'd63, 6'd31, 64'hAB);
        send(2'd2, 64'h5, 64'hFFFF, 6'd60, 6'd3, 6'd32, 64'hFF5F);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || {out_tag, out_res} !== exp_q[0]) begin
            errors++; $display("FAIL arst_pre: valid=%b out=%h required 1/%h", out_valid, {out_tag, out_res}, exp_q[0]);
        end
        base = obs_q.size();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_res !== 64'h0) begin
            errors++; $display("FAIL arst_now: valid=%b ready=%b res=%h required 0/1/0", out_valid, in_ready, out_res);
        end
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (obs_q.size() != base) begin
            errors++; $display("FAIL arst_lost: outputs=%0d required 0", obs_q.size() - base);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
